// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-drive bundle between the sequencer and its environment.
// master = control logic plus ALU datapath; slave = alu_op_sequencer.
interface alu_op_sequencer_if #(
    parameter int W = 16
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_code;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_result;
    logic           alu_cout;
    logic           alu_overflow;
    logic           alu_zero;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_lo;
    logic [W-1:0]   rsp_hi;
    logic [2:0]     rsp_flags;
    logic           rsp_err;

    modport master (
        output cmd_valid, cmd_code, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_cout, alu_overflow, alu_zero,
        input  rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_a, cmd_b,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_cout, alu_overflow, alu_zero,
        output rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences single ALU ops and a W-iteration shift-add multiply onto one shared ALU.
// Latency from accept edge: 2 edges for ALU ops/illegal codes, W+1 for MUL (ALU_SEQ_MUL_EN only).
// Backpressure: response held stable until rsp_ready; cmd_ready only high in IDLE.
module alu_op_sequencer #(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b010;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
    localparam int KW = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    logic [W-1:0]  mq_q;
    logic [KW-1:0] k_q;
    logic [W:0]    sum;
    logic          is_mul;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t       state_q, state_d;
    logic         illegal;
    logic         err_q;
    logic [W-1:0] alu_a_q, alu_b_q;
    logic [2:0]   alu_op_q;
    logic [W-1:0] rsp_lo_q, rsp_hi_q;
    logic [2:0]   rsp_flags_q;
    logic         rsp_err_q;

`ifdef ALU_SEQ_MUL_EN
    assign is_mul  = (bus.cmd_code == 4'b1000);
    assign illegal = bus.cmd_code[3] & ~is_mul;
    // alu_a_q doubles as the accumulator; the ALU computes acc + a every MUL cycle
    assign sum     = mq_q[0] ? {bus.alu_cout, bus.alu_result} : {1'b0, alu_a_q};
`else
    assign illegal = bus.cmd_code[3];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    state_d = is_mul ? MUL : EXEC;
`else
                    state_d = EXEC;
`endif
                end
            end
            EXEC: state_d = RESP;
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                if (k_q == K_LAST) state_d = RESP;
            end
`endif
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mq_q        <= '0;
            k_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        err_q <= illegal;
`ifdef ALU_SEQ_MUL_EN
                        if (is_mul) begin
                            alu_a_q  <= '0;
                            alu_b_q  <= bus.cmd_a;
                            alu_op_q <= OP_ADD;
                            mq_q     <= bus.cmd_b;
                            k_q      <= '0;
                        end else
`endif
                        // illegal codes leave the ALU drive untouched
                        if (!illegal) begin
                            alu_a_q  <= bus.cmd_a;
                            alu_b_q  <= bus.cmd_b;
                            alu_op_q <= bus.cmd_code[2:0];
                        end
                    end
                end
                EXEC: begin
                    rsp_hi_q  <= '0;
                    rsp_err_q <= err_q;
                    if (err_q) begin
                        rsp_lo_q    <= '0;
                        rsp_flags_q <= '0;
                    end else begin
                        rsp_lo_q    <= bus.alu_result;
                        rsp_flags_q <= {bus.alu_overflow, bus.alu_zero, bus.alu_cout};
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    alu_a_q <= sum[W:1];
                    mq_q    <= {sum[0], mq_q[W-1:1]};
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        rsp_hi_q    <= sum[W:1];
                        rsp_lo_q    <= {sum[0], mq_q[W-1:1]};
                        rsp_flags_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
